// File: rtl/gray_histogram.sv
// 256-bin histogram of gray samples: clears the bin array, accumulates PIXELS
// samples (clamped to 255, saturating counts), then streams every bin out.
module gray_histogram #(
    parameter int PIXELS = 64,
    parameter int BIN_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      gray_in,
    input  logic             valid_in,
    output logic             in_ready,
    input  logic             start,
    output logic             busy,
    output logic [7:0]       bin_idx,
    output logic [BIN_W-1:0] bin_count,
    output logic             bin_valid,
    input  logic             bin_ready,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, READ} state_t;

    localparam logic [15:0]      LAST    = 16'(PIXELS - 1);
    localparam logic [BIN_W-1:0] BIN_MAX = '1;

    state_t           state_q, state_d;
    logic [7:0]       clr_idx_q, clr_idx_d;
    logic [7:0]       bin_idx_q, bin_idx_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             bin_valid_q, bin_valid_d;
    logic             done_q, done_d;

    logic [BIN_W-1:0] bins_q [256];
    logic             wr_en;
    logic [7:0]       wr_addr;
    logic [BIN_W-1:0] wr_data;
    logic             accept;
    logic [7:0]       sel;

    // in_ready_q is only ever high in ACCUM, so it alone qualifies a sample
    assign accept = valid_in && in_ready_q;
    assign sel    = (|gray_in[31:8]) ? 8'hFF : gray_in[7:0];

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = sel;
        wr_data = bins_q[sel];
        if (state_q == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_idx_q;
            wr_data = '0;
        end else if (accept && bins_q[sel] != BIN_MAX) begin
            wr_en   = 1'b1;
            wr_data = bins_q[sel] + 1'b1;
        end
    end

    // Bin storage is deliberately not reset; CLEAR zeroes it before use
    always_ff @(posedge clk) begin
        if (rst && wr_en)
            bins_q[wr_addr] <= wr_data;
    end

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        bin_idx_d   = bin_idx_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        bin_valid_d = bin_valid_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = CLEAR;
                    clr_idx_d = 8'd0;
                    busy_d    = 1'b1;
                end
            end
            CLEAR: begin
                clr_idx_d = clr_idx_q + 8'd1;
                if (clr_idx_q == 8'hFF) begin
                    state_d    = ACCUM;
                    in_ready_d = 1'b1;
                    cnt_d      = 16'd0;
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (cnt_q == LAST) begin
                        state_d     = READ;
                        cnt_d       = 16'd0;
                        in_ready_d  = 1'b0;
                        bin_valid_d = 1'b1;
                        bin_idx_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            READ: begin
                if (bin_ready) begin
                    bin_idx_d = bin_idx_q + 8'd1;
                    if (bin_idx_q == 8'hFF) begin
                        state_d     = IDLE;
                        bin_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            clr_idx_q   <= 8'd0;
            bin_idx_q   <= 8'd0;
            cnt_q       <= 16'd0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            bin_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            bin_idx_q   <= bin_idx_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            bin_valid_q <= bin_valid_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign bin_idx   = bin_idx_q;
    assign bin_valid = bin_valid_q;
    assign done      = done_q;
    assign bin_count = bin_valid_q ? bins_q[bin_idx_q] : '0;

endmodule

// File: tb/tb_gray_histogram.sv
// Bench for gray_histogram: three configurations share one stimulus stream
// and are checked against a per-configuration histogram model.
module tb_gray_histogram;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] gray_in = '0;
    logic        valid_in = 1'b0;
    logic        start = 1'b0;
    logic        brdy [3];

    logic        in_ready_w [3];
    logic        busy_w [3];
    logic [7:0]  idx_w [3];
    logic        valid_w [3];
    logic        done_w [3];
    logic [31:0] cnt_w [3];
    logic [15:0] bc0, bc1;
    logic [1:0]  bc2;

    int PIX [3] = '{8, 4, 6};
    int BW  [3] = '{16, 16, 2};
    int exp_bins [3][256];
    int acc [3];
    int rd [3];
    int eidx [3];
    logic [31:0] lst [4] = '{32'd300, 32'hFFFF_FFFF, 32'd255, 32'd0};

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gray_histogram #(.PIXELS(8), .BIN_W(16)) u0 (
        .clk(clk), .rst(rst), .gray_in(gray_in), .valid_in(valid_in),
        .in_ready(in_ready_w[0]), .start(start), .busy(busy_w[0]),
        .bin_idx(idx_w[0]), .bin_count(bc0), .bin_valid(valid_w[0]),
        .bin_ready(brdy[0]), .done(done_w[0]));

    gray_histogram #(.PIXELS(4), .BIN_W(16)) u1 (
        .clk(clk), .rst(rst), .gray_in(gray_in), .valid_in(valid_in),
        .in_ready(in_ready_w[1]), .start(start), .busy(busy_w[1]),
        .bin_idx(idx_w[1]), .bin_count(bc1), .bin_valid(valid_w[1]),
        .bin_ready(brdy[1]), .done(done_w[1]));

    gray_histogram #(.PIXELS(6), .BIN_W(2)) u2 (
        .clk(clk), .rst(rst), .gray_in(gray_in), .valid_in(valid_in),
        .in_ready(in_ready_w[2]), .start(start), .busy(busy_w[2]),
        .bin_idx(idx_w[2]), .bin_count(bc2), .bin_valid(valid_w[2]),
        .bin_ready(brdy[2]), .done(done_w[2]));

    assign cnt_w[0] = {16'd0, bc0};
    assign cnt_w[1] = {16'd0, bc1};
    assign cnt_w[2] = {30'd0, bc2};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rnd_gray();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return 32'($urandom_range(0, 15));
        if (r < 8) return 32'($urandom_range(0, 255));
        return $urandom;
    endfunction

    function automatic logic [31:0] gen(input int mode, input int k);
        case (mode)
            1: return 32'd5;
            2: return (k < 4) ? lst[k] : rnd_gray();
            3: return 32'd7;
            default: return rnd_gray();
        endcase
    endfunction

    task automatic check_reset_outs();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_busy%0d", d), 32'(busy_w[d]), 0);
            chk($sformatf("rst_in_ready%0d", d), 32'(in_ready_w[d]), 0);
            chk($sformatf("rst_bin_valid%0d", d), 32'(valid_w[d]), 0);
            chk($sformatf("rst_done%0d", d), 32'(done_w[d]), 0);
            chk($sformatf("rst_bin_idx%0d", d), 32'(idx_w[d]), 0);
            chk($sformatf("rst_bin_count%0d", d), cnt_w[d], 0);
        end
    endtask

    // abort_after >= 0: pulse reset (with start held) once that many samples are in
    task automatic run_frame(input int mode, input int abort_after);
        int k, cyc, stall;
        logic v;
        logic [31:0] g, b;
        bit pending;
        for (int c = 0; c < 3; c++) begin
            valid_in = 1'($urandom_range(0, 1));
            gray_in  = rnd_gray();
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("clr_busy%0d", d), 32'(busy_w[d]), 1);
            chk($sformatf("clr_in_ready%0d", d), 32'(in_ready_w[d]), 0);
        end
        for (int c = 1; c < 256; c++) begin
            valid_in = 1'($urandom_range(0, 1));
            gray_in  = rnd_gray();
            start    = 1'($urandom_range(0, 7) == 0);
            @(posedge clk); #1;
        end
        for (int d = 0; d < 3; d++)
            chk($sformatf("clr_last_in_ready%0d", d), 32'(in_ready_w[d]), 0);
        valid_in = 1'($urandom_range(0, 1));
        start = 1'b0;
        @(posedge clk); #1;

        for (int d = 0; d < 3; d++) begin
            acc[d] = 0;
            for (int i = 0; i < 256; i++) exp_bins[d][i] = 0;
        end
        k = 0;
        cyc = 0;
        while ((acc[0] < PIX[0] || acc[1] < PIX[1] || acc[2] < PIX[2]) && cyc < 200) begin
            for (int d = 0; d < 3; d++)
                chk($sformatf("acc_in_ready%0d", d), 32'(in_ready_w[d]), 32'(acc[d] < PIX[d]));
            v = 1'($urandom_range(0, 3) != 0);
            g = gen(mode, k);
            valid_in = v;
            gray_in  = g;
            start    = 1'($urandom_range(0, 7) == 0);
            if (abort_after >= 0 && k == abort_after) begin
                rst = 1'b0;
                start = 1'b1;
                @(posedge clk); #1;
                rst = 1'b1;
                start = 1'b0;
                valid_in = 1'b0;
                check_reset_outs();
                @(posedge clk); #1;
                for (int d = 0; d < 3; d++)
                    chk($sformatf("rst_start_ignored%0d", d), 32'(busy_w[d]), 0);
                return;
            end
            @(posedge clk);
            if (v) begin
                b = (g > 32'd255) ? 32'd255 : g;
                for (int d = 0; d < 3; d++) begin
                    if (acc[d] < PIX[d]) begin
                        if (exp_bins[d][b] < (1 << BW[d]) - 1) exp_bins[d][b]++;
                        acc[d]++;
                    end
                end
                k++;
            end
            #1;
            cyc++;
        end
        start = 1'b0;
        valid_in = 1'b0;
        if (cyc >= 200) chk("accum_timeout", 0, 1);

        for (int d = 0; d < 3; d++) begin
            rd[d] = 0;
            eidx[d] = 0;
        end
        stall = 0;
        cyc = 0;
        while ((rd[0] != 2 || rd[1] != 2 || rd[2] != 2) && cyc < 4000) begin
            for (int d = 0; d < 3; d++) begin
                case (rd[d])
                    0: begin
                        chk($sformatf("rd_valid%0d", d), 32'(valid_w[d]), 1);
                        chk($sformatf("rd_idx%0d", d), 32'(idx_w[d]), 32'(eidx[d]));
                        chk($sformatf("rd_count%0d_bin%0d", d, eidx[d]), cnt_w[d],
                            32'(exp_bins[d][eidx[d]]));
                        chk($sformatf("rd_done_early%0d", d), 32'(done_w[d]), 0);
                        chk($sformatf("rd_busy%0d", d), 32'(busy_w[d]), 1);
                    end
                    1: begin
                        chk($sformatf("done_pulse%0d", d), 32'(done_w[d]), 1);
                        chk($sformatf("done_busy%0d", d), 32'(busy_w[d]), 0);
                        chk($sformatf("done_valid%0d", d), 32'(valid_w[d]), 0);
                        rd[d] = 2;
                    end
                    default: begin
                        chk($sformatf("idle_done%0d", d), 32'(done_w[d]), 0);
                        chk($sformatf("idle_valid%0d", d), 32'(valid_w[d]), 0);
                    end
                endcase
            end
            for (int d = 0; d < 3; d++) begin
                brdy[d] = 1'($urandom_range(0, 3) != 0);
                if (d == 0 && rd[0] == 0 && eidx[0] == 10 && stall < 5) begin
                    brdy[0] = 1'b0;
                    stall++;
                end
            end
            valid_in = 1'($urandom_range(0, 1));
            gray_in  = rnd_gray();
            @(posedge clk);
            for (int d = 0; d < 3; d++) begin
                pending = (rd[d] == 0) && brdy[d];
                if (pending) begin
                    if (eidx[d] == 255) rd[d] = 1;
                    else eidx[d]++;
                end
            end
            #1;
            cyc++;
        end
        for (int d = 0; d < 3; d++) brdy[d] = 1'b0;
        valid_in = 1'b0;
        if (cyc >= 4000) chk("read_timeout", 0, 1);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) brdy[d] = 1'b0;
        rst = 1'b0;
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outs();
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++)
            chk($sformatf("post_rst_idle%0d", d), 32'(busy_w[d]), 0);

        run_frame(1, -1);
        run_frame(2, -1);
        run_frame(3, -1);
        run_frame(0, 3);
        run_frame(0, -1);
        run_frame(0, -1);
        run_frame(0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gray_histogram.md
GRAY_HISTOGRAM -- requirements
Module: gray_histogram

Interface
REQ-001 Parameter PIXELS, default 64: number of gray samples accumulated per frame (1..65535).
REQ-002 Parameter BIN_W, default 16: width of each bin counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset (rst=0 sampled on clk edge resets the block).
REQ-005 gray_in  input  32  gray sample from the upstream RGB-to-gray stage.
REQ-006 valid_in  input  1  gray_in valid this cycle.
REQ-007 in_ready  output  1  block accepts samples; a sample is taken only when valid_in && in_ready.
REQ-008 start  input  1  one-cycle request to begin a new frame.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 bin_idx  output  8  index of the bin being presented.
REQ-011 bin_count  output  BIN_W  count of bin bin_idx.
REQ-012 bin_valid  output  1  bin_idx/bin_count valid.
REQ-013 bin_ready  input  1  downstream accepts the presented bin.
REQ-014 done  output  1  one-cycle pulse after the last bin is accepted.

Function
REQ-015 FSM states SHALL be IDLE, CLEAR, ACCUM, READ; IDLE->CLEAR on start; CLEAR->ACCUM after 256 cycles; ACCUM->READ after PIXELS accepted samples; READ->IDLE after bin 255 handshake.
REQ-016 start SHALL be ignored in every state except IDLE.
REQ-017 CLEAR SHALL zero one bin per cycle, bins 0..255 in order, exactly 256 cycles.
REQ-018 in_ready SHALL be high only in ACCUM; valid_in outside ACCUM SHALL be ignored with no bin or counter change.
REQ-019 Bin selection: gray_in <= 255 -> bin gray_in[7:0]; gray_in > 255 -> bin 255 (clamp).
REQ-020 An accepted sample SHALL increment its bin on the same clock edge; back-to-back samples to the same bin on consecutive cycles SHALL each count (no lost increments).
REQ-021 A bin at 2^BIN_W-1 SHALL saturate, not wrap.
REQ-022 Accepted-sample counter SHALL count 0..PIXELS-1; the edge accepting sample PIXELS SHALL move the FSM to READ, and in_ready SHALL be low the following cycle.
REQ-023 On READ entry, bin_idx=0 and bin_valid=1; bin_count SHALL equal the stored count of bin_idx combinationally from the bin array or registered, but valid in the same cycle as bin_valid.
REQ-024 bin_idx/bin_count SHALL hold stable while bin_valid && !bin_ready.
REQ-025 On bin_valid && bin_ready, bin_idx SHALL advance by 1; handshake on bin 255 SHALL drop bin_valid next cycle, pulse done for one cycle, and return to IDLE.
REQ-026 bin_valid SHALL be low outside READ; bin_ready outside READ SHALL be ignored.
REQ-027 busy SHALL be low in IDLE, including the cycle done is high.

Reset
REQ-028 On rst=0: state IDLE; in_ready, busy, bin_valid, done = 0; bin_idx = 0; bin_count = 0; sample counter = 0.
REQ-029 Reset SHALL abort any state mid-operation within one cycle; bin contents need not be cleared by reset (CLEAR guarantees zero before accumulation).
REQ-030 A start asserted in the same cycle as rst=0 SHALL be ignored.

Verification
REQ-031 PIXELS=8: start, 256 clear cycles, feed 8 samples all gray_in=5, bin_ready=1 -> bin 5 = 8, all other bins 0, 256 bin handshakes, done pulse once.
REQ-032 PIXELS=4: samples 300, 0xFFFFFFFF, 255, 0 -> bin 255 = 3, bin 0 = 1.
REQ-033 BIN_W=2, PIXELS=6, all gray_in=7 -> bin 7 = 3 (saturated).
REQ-034 READ with bin_ready low 5 cycles at bin_idx=10 -> bin_idx/bin_count stable, no advance; resumes on bin_ready=1.
REQ-035 valid_in pulses during IDLE/CLEAR/READ and start during ACCUM -> no effect on bins, counter, or state.
REQ-036 rst=0 during ACCUM after 3 samples, then new frame -> previous samples absent, counts reflect only new frame.
